// File: rtl/wb_pipe_if.sv
// Result-pipeline bundle: EX result in, regfile writeback out, forwarding ports to ID.
// Latency: none; signal bundle only.
// Backpressure: stall_i travels with the bundle; the master holds in_* while stall_i is high.
interface wb_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic                  stall_i;
   logic                  flush_i;
   logic                  in_wreg_i;
   logic [ADDR_W-1:0]     in_wd_i;
   logic [DATA_W-1:0]     in_wdata_i;
   logic [NRD*ADDR_W-1:0] rd_addr_i;
   logic [NRD*DATA_W-1:0] rd_data_i;
   logic [NRD*DATA_W-1:0] fwd_data_o;
   logic [NRD-1:0]        fwd_hit_o;
   logic                  wb_we_o;
   logic [ADDR_W-1:0]     wb_waddr_o;
   logic [DATA_W-1:0]     wb_wdata_o;
   logic [31:0]           retire_cnt_o;
   logic [31:0]           stall_cnt_o;

   // Pipeline control / EX / ID side drives inputs and observes results
   modport master (
      output stall_i, flush_i, in_wreg_i, in_wd_i, in_wdata_i, rd_addr_i, rd_data_i,
      input  fwd_data_o, fwd_hit_o, wb_we_o, wb_waddr_o, wb_wdata_o, retire_cnt_o, stall_cnt_o
   );

   // The result pipeline itself
   modport slave (
      input  stall_i, flush_i, in_wreg_i, in_wd_i, in_wdata_i, rd_addr_i, rd_data_i,
      output fwd_data_o, fwd_hit_o, wb_we_o, wb_waddr_o, wb_wdata_o, retire_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/wb_pipe.sv
// Parametrised EX->WB result pipeline with stall, partial flush and NRD-port operand forwarding.
// Latency: DEPTH cycles from in_* presentation to regfile write; forwarding is combinational.
// Backpressure: stall_i freezes every stage and blocks writeback; optional counters under WB_PIPE_STATS_EN.
module wb_pipe #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int DEPTH       = 2,
   parameter int NRD         = 2,
   parameter int FLUSH_DEPTH = 1
) (
   input logic       clk,
   input logic       rst,
   wb_pipe_if.slave  bus
);

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] wd;
      logic [DATA_W-1:0] dat;
   } stage_t;

   stage_t st   [DEPTH];
   stage_t prev [DEPTH];
   stage_t nxt  [DEPTH];

   logic [NRD*DATA_W-1:0] fwd_data;
   logic [NRD-1:0]        fwd_hit;
   logic [ADDR_W-1:0]     fa;
   logic                  in_live;

   // A flush kills the incoming result along with the young stages
   assign in_live = bus.in_wreg_i & ~bus.flush_i;

   // Candidate source for each stage: incoming result for stage 0, older neighbour otherwise
   always_comb begin
      prev[0].vld = in_live;
      prev[0].wd  = bus.in_wd_i;
      prev[0].dat = bus.in_wdata_i;
      for (int i = 1; i < DEPTH; i++) begin
         prev[i] = st[i-1];
      end
   end

   // Next-state selection: advance, hold on stall, bubble the flushed region and its successor
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         nxt[i] = st[i];
      end
      if (bus.flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i < FLUSH_DEPTH) begin
               nxt[i] = '0;
            end else if (!bus.stall_i) begin
               nxt[i] = (i == FLUSH_DEPTH) ? '0 : prev[i];
            end
         end
      end else if (!bus.stall_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = prev[i];
         end
      end
   end

   // Stage registers; reset wins over stall and flush
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            st[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            st[i] <= nxt[i];
         end
      end
   end

   // Writeback from the oldest stage; only on the cycle it actually leaves, never to x0
   assign bus.wb_we_o    = st[DEPTH-1].vld & (st[DEPTH-1].wd != '0) & ~bus.stall_i;
   assign bus.wb_waddr_o = st[DEPTH-1].wd;
   assign bus.wb_wdata_o = st[DEPTH-1].dat;

   // Forwarding: scan oldest to youngest so the youngest match overwrites; x0 always reads zero
   always_comb begin
      fwd_data = '0;
      fwd_hit  = '0;
      fa       = '0;
      for (int k = 0; k < NRD; k++) begin
         fa = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
         if (fa != '0) begin
            fwd_data[k*DATA_W +: DATA_W] = bus.rd_data_i[k*DATA_W +: DATA_W];
            for (int i = DEPTH-1; i >= 0; i--) begin
               if (st[i].vld && (st[i].wd == fa)) begin
                  fwd_data[k*DATA_W +: DATA_W] = st[i].dat;
                  fwd_hit[k] = 1'b1;
               end
            end
            if (in_live && (bus.in_wd_i == fa)) begin
               fwd_data[k*DATA_W +: DATA_W] = bus.in_wdata_i;
               fwd_hit[k] = 1'b1;
            end
         end
      end
   end

   assign bus.fwd_data_o = fwd_data;
   assign bus.fwd_hit_o  = fwd_hit;

`ifdef WB_PIPE_STATS_EN
   logic [31:0] retire_cnt;
   logic [31:0] stall_cnt;

   // Free-running wrap-around event counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (bus.wb_we_o) retire_cnt <= retire_cnt + 32'd1;
         if (bus.stall_i) stall_cnt  <= stall_cnt + 32'd1;
      end
   end

   assign bus.retire_cnt_o = retire_cnt;
   assign bus.stall_cnt_o  = stall_cnt;
`else
   assign bus.retire_cnt_o = '0;
   assign bus.stall_cnt_o  = '0;
`endif

endmodule

// File: doc/wb_pipe.md
Name: wb_pipe

Overview:
- Parametrised result pipeline. Carries EX-stage register write results (write enable, destination, data) through DEPTH registered stages to the regfile write port.
- Generalises the fixed EX/MEM and MEM/WB register pair.
- Adds stall, selective flush, and NRD-port operand forwarding with x0 suppression, replacing per-stage forwarding wires into the decoder.
- Sits between the EX unit and regfile; forwarding outputs feed the ID stage.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
DEPTH, 2, number of registered stages (>=1); stage 0 youngest, stage DEPTH-1 drives writeback
NRD, 2, number of forwarding read ports (>=1)
FLUSH_DEPTH, 1, stages 0..FLUSH_DEPTH-1 cleared by flush (0..DEPTH)

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset, synchronous, active-low
stall_i  in  1  hold all stages
flush_i  in  1  kill young stages and incoming result
in_wreg_i  in  1  incoming result valid/write enable (from EX)
in_wd_i  in  ADDR_W  incoming destination
in_wdata_i  in  DATA_W  incoming data
rd_addr_i  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data_i  in  NRD*DATA_W  regfile read data per port
fwd_data_o  out  NRD*DATA_W  forwarded operand per port
fwd_hit_o  out  NRD  port k satisfied from in-flight result
wb_we_o  out  1  regfile write enable
wb_waddr_o  out  ADDR_W  regfile write address
wb_wdata_o  out  DATA_W  regfile write data
retire_cnt_o  out  32  writes retired (optional feature)
stall_cnt_o  out  32  cycles with stall_i=1 (optional feature)

Behaviour:
- Reset: on posedge clk with rst=0, all stage valid, address and data bits clear to 0. Outputs after reset: wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0, counters 0. Reset overrides stall and flush.
- Stage entry: valid, wd, wdata. A stage with valid=0 is a bubble.
- Advance (stall_i=0, flush_i=0), per edge: stage0 <= in_*; stage[i] <= stage[i-1].
- Stall (stall_i=1, flush_i=0): all stages hold; incoming result is not captured (upstream holds it).
- Flush (flush_i=1, priority over stall):
  - Stages 0..FLUSH_DEPTH-1 become bubbles after the edge.
  - Incoming result is discarded.
  - Older stages advance normally if stall_i=0 and hold if stall_i=1. The stage directly after the flushed region takes a bubble, not flushed data.
- Writeback is combinational from the last stage:
  - wb_we_o = stage[DEPTH-1].valid & (wd!=0) & ~stall_i
  - wb_waddr_o / wb_wdata_o = stage[DEPTH-1] fields.
  - A write occurs exactly once, in the cycle the entry leaves the pipe. Writes to x0 are never issued.
- Latency: result presented on in_* at edge N (no stall) -> wb_we_o high during the cycle after edge N+DEPTH-1, i.e. DEPTH cycles after presentation.
- Forwarding (combinational, per port k):
  - Candidate priority: in_* (if in_wreg_i & ~flush_i), then stage0, stage1, ..., stage[DEPTH-1]. Youngest match wins.
  - Match requires valid & wd==rd_addr & rd_addr!=0.
  - Hit: fwd_data=matching data, fwd_hit=1. Miss: fwd_data=rd_data_i slice, fwd_hit=0.
  - rd_addr=0: fwd_data=0, fwd_hit=0, regardless of rd_data_i.
- Simultaneous write and read of the same address in the writeback cycle: forwarded from stage[DEPTH-1]; the regfile read value is ignored.

Optional Feature:
WB_PIPE_STATS_EN
- Defined:
  - retire_cnt_o increments on every cycle with wb_we_o=1.
  - stall_cnt_o increments on every cycle with stall_i=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- DEPTH=2: reset, then in_wreg=1, wd=5, wdata=0x11 for one cycle -> wb_we_o=1, waddr=5, wdata=0x11 exactly 2 cycles later, single cycle; all outputs 0 during reset.
- Back-to-back writes to x3 (0xA, then 0xB), read port 0 addr 3 -> fwd_hit=1 with 0xA while 0xA alone in flight, then 0xB as soon as 0xB presented; rd_addr=0 with rd_data=0xFFFF -> fwd_data=0, hit=0.
- Entry in last stage, stall_i=1 for 3 cycles -> wb_we_o=0 throughout, forwarding still hits; release -> one write; stall_cnt_o=3 with WB_PIPE_STATS_EN.
- DEPTH=3, FLUSH_DEPTH=1, pipe full (wd=1,2,3 youngest->oldest), flush_i=1 with in_wd=4 -> wd=1 and wd=4 never written; wd=2 and wd=3 written in order.
- Write to x0 with wdata=0x55 -> wb_we_o never asserted, no forward hit on port with rd_addr=0; retire_cnt_o unchanged.
- Reset asserted while stalled with full pipe -> all stages cleared next edge, no writeback after reset release.
